// File: rtl/pll_reset_sequencer_if.sv
// Bundles the PLL lock input with the reset and timebase outputs of
// pll_reset_sequencer. The sequencer connects to the slave modport and
// its environment connects to the master modport.
interface pll_reset_sequencer_if;
  logic       pll_lock;
  logic       rst_out;
  logic       rst_out_n;
  logic [1:0] seq_state;
  logic       tick_us;
  logic       tick_ms;

  modport slave (
    input  pll_lock,
    output rst_out, rst_out_n, seq_state, tick_us, tick_ms
  );

  modport master (
    output pll_lock,
    input  rst_out, rst_out_n, seq_state, tick_us, tick_ms
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer. It resynchronises and debounces the PLL lock, then
// holds the user reset for a fixed time before releasing it. Any lock loss
// re-asserts the reset at once.
// Optional feature macro: SEQ_TICKS_EN. When it is defined, the sequencer
// also produces 1 us and 1 ms strobes while in RUN. When it is not defined,
// both strobes are tied low.
module pll_reset_sequencer #(
  parameter int CLK_MHZ     = 60,
  parameter int LOCK_STABLE = 1024,
  parameter int HOLD_CYCLES = 65536
) (
  input  logic                  clock,
  input  logic                  reset,
  pll_reset_sequencer_if.slave  bus
);

  localparam int STAB_W = $clog2(LOCK_STABLE + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE - 1);
  localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(LOCK_STABLE);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } seqState_t;

  seqState_t         r_state;
  seqState_t         w_nextState;
  logic              r_sync1;
  logic              r_sync2;
  logic              w_lk;
  logic [STAB_W-1:0] r_stabCnt;
  logic [HOLD_W-1:0] r_holdCnt;
  logic              r_rstOut;
  logic              r_rstOutN;

  // Resynchronise the asynchronous lock input with two flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.pll_lock;
      r_sync2 <= r_sync1;
    end
  end

  assign w_lk = r_sync2;

  // Next-state logic. Lock loss always takes priority over the terminal counts.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      WAIT_LOCK: if (w_lk && (r_stabCnt == STAB_LAST)) w_nextState = HOLD;
      HOLD: begin
        if (!w_lk)                        w_nextState = WAIT_LOCK;
        else if (r_holdCnt == HOLD_LAST)  w_nextState = RUN;
      end
      RUN:       if (!w_lk) w_nextState = WAIT_LOCK;
      default:   w_nextState = WAIT_LOCK;
    endcase
  end

  // State register. The reset outputs are registered from the next state,
  // so they change on the same edge as seq_state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= WAIT_LOCK;
      r_rstOut  <= 1'b1;
      r_rstOutN <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_rstOut  <= (w_nextState != RUN);
      r_rstOutN <= (w_nextState == RUN);
    end
  end

  // Lock stability counter. It saturates while lk is high in WAIT_LOCK and
  // clears whenever lk is low or the state is anything other than WAIT_LOCK.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stabCnt <= '0;
    end else if ((r_state == WAIT_LOCK) && w_lk) begin
      if (r_stabCnt != STAB_MAX) r_stabCnt <= r_stabCnt + 1'b1;
    end else begin
      r_stabCnt <= '0;
    end
  end

  // Reset-stretch counter. It counts only in HOLD and is zero on entry to HOLD.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_holdCnt <= '0;
    end else if (r_state == HOLD) begin
      if (r_holdCnt != HOLD_LAST) r_holdCnt <= r_holdCnt + 1'b1;
    end else begin
      r_holdCnt <= '0;
    end
  end

  assign bus.rst_out   = r_rstOut;
  assign bus.rst_out_n = r_rstOutN;
  assign bus.seq_state = r_state;

`ifdef SEQ_TICKS_EN
  localparam int US_W = $clog2(CLK_MHZ + 1);
  localparam logic [US_W-1:0] US_LAST = US_W'(CLK_MHZ - 1);

  logic [US_W-1:0] r_usCnt;
  logic [9:0]      r_msCnt;
  logic            r_tickUs;
  logic            r_tickMs;
  logic            w_stayRun;
  logic            w_usWrap;
  logic            w_msWrap;

  assign w_stayRun = (r_state == RUN) && (w_nextState == RUN);
  assign w_usWrap  = w_stayRun && (r_usCnt == US_LAST);
  assign w_msWrap  = w_usWrap && (r_msCnt == 10'd999);

  // Timebase counters. They run only while the sequencer stays in RUN and
  // are cleared, with both strobes forced low, whenever it leaves RUN.
  always_ff @(posedge clock) begin
    if (reset || !w_stayRun) begin
      r_usCnt  <= '0;
      r_msCnt  <= '0;
      r_tickUs <= 1'b0;
      r_tickMs <= 1'b0;
    end else begin
      r_usCnt  <= w_usWrap ? '0 : r_usCnt + 1'b1;
      if (w_usWrap) r_msCnt <= w_msWrap ? 10'd0 : r_msCnt + 10'd1;
      r_tickUs <= w_usWrap;
      r_tickMs <= w_msWrap;
    end
  end

  assign bus.tick_us = r_tickUs;
  assign bus.tick_ms = r_tickMs;
`else
  assign bus.tick_us = 1'b0;
  assign bus.tick_ms = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer, built with LOCK_STABLE=4, HOLD_CYCLES=8
// and CLK_MHZ=3.
// The stimulus process queues each expected state or tick event, with the
// cycle number at which it must appear. Monitor processes pop these events
// and compare them when the DUT outputs change.
module tb_pll_reset_sequencer;

  localparam int CLK_MHZ     = 3;
  localparam int LOCK_STABLE = 4;
  localparam int HOLD_CYCLES = 8;

  typedef struct {
    int         atCyc;
    logic       rst;
    logic [1:0] st;
  } stateEv_t;

  typedef struct {
    int   atCyc;
    logic ms;
  } tickEv_t;

  logic       clock = 1'b0;
  logic       reset;
  int         cyc = 0;
  int         tests = 0;
  int         failed = 0;
  int         tickHigh = 0;
  logic       monEn = 1'b0;
  logic       tickCheckEn = 1'b0;
  logic       prevRst;
  logic [1:0] prevState;
  stateEv_t   stateQ[$];
  tickEv_t    tickQ[$];
  stateEv_t   stEv;
  tickEv_t    tkEv;
  int         n, m, p, q, s, e;

  pll_reset_sequencer_if ifc();

  pll_reset_sequencer #(
    .CLK_MHZ     (CLK_MHZ),
    .LOCK_STABLE (LOCK_STABLE),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
  );

  // Free-running clock. cyc counts rising edges, so at each falling edge it
  // equals the index of the rising edge just taken.
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic rstIn, input logic lockIn);
    reset        = rstIn;
    ifc.pll_lock = lockIn;
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic pushState(input int atCyc, input logic rst, input logic [1:0] st);
    stEv.atCyc = atCyc;
    stEv.rst   = rst;
    stEv.st    = st;
    stateQ.push_back(stEv);
  endtask

  // State monitor. Any change of rst_out or seq_state must match the next
  // queued event.
  always @(negedge clock) begin
    if (monEn) begin
      if ((ifc.rst_out !== prevRst) || (ifc.seq_state !== prevState)) begin
        checkOutput("stateEventPending", int'(stateQ.size() > 0), 1);
        if (stateQ.size() > 0) begin
          stEv = stateQ.pop_front();
          checkOutput("stateEventCycle", cyc, stEv.atCyc);
          checkOutput("rst_out", int'(ifc.rst_out), int'(stEv.rst));
          checkOutput("rst_out_n", int'(ifc.rst_out_n), int'(!stEv.rst));
          checkOutput("seq_state", int'(ifc.seq_state), int'(stEv.st));
        end
        prevRst   = ifc.rst_out;
        prevState = ifc.seq_state;
      end
      if (ifc.tick_us || ifc.tick_ms) tickHigh++;
    end
  end

`ifdef SEQ_TICKS_EN
  // Tick monitor. Each strobe seen in the checked window must match the next
  // queued tick.
  always @(negedge clock) begin
    if (tickCheckEn && (ifc.tick_us || ifc.tick_ms)) begin
      checkOutput("tickEventPending", int'(tickQ.size() > 0), 1);
      if (tickQ.size() > 0) begin
        tkEv = tickQ.pop_front();
        checkOutput("tickCycle", cyc, tkEv.atCyc);
        checkOutput("tick_us", int'(ifc.tick_us), 1);
        checkOutput("tick_ms", int'(ifc.tick_ms), int'(tkEv.ms));
      end
    end
  end
`endif

  initial begin
    applyStimulus(1'b1, 1'b0);
    repeat (3) @(negedge clock);

    // Values expected after reset.
    checkOutput("resetRstOut", int'(ifc.rst_out), 1);
    checkOutput("resetRstOutN", int'(ifc.rst_out_n), 0);
    checkOutput("resetSeqState", int'(ifc.seq_state), 0);
    checkOutput("resetTickUs", int'(ifc.tick_us), 0);
    checkOutput("resetTickMs", int'(ifc.tick_ms), 0);
    prevRst   = ifc.rst_out;
    prevState = ifc.seq_state;
    monEn     = 1'b1;

    // Lock held steady from reset release: HOLD at +6, RUN at +14.
    n = cyc;
    applyStimulus(1'b0, 1'b1);
    pushState(n + 6, 1'b1, 2'd1);
    pushState(n + 14, 1'b0, 2'd2);
    waitUntil(n + 20);

    // One-cycle lock loss in RUN. Reset reasserts two sync cycles plus one
    // edge later, then the sequence repeats.
    m = cyc;
    applyStimulus(1'b0, 1'b0);
    pushState(m + 3, 1'b1, 2'd0);
    pushState(m + 7, 1'b1, 2'd1);
    pushState(m + 15, 1'b0, 2'd2);
    waitUntil(m + 1);
    applyStimulus(1'b0, 1'b1);
    waitUntil(m + 20);

    // Lose lock, then apply a glitch with 3 cycles high, 1 cycle low, then
    // high again. The third stable cycle does not qualify because the glitch
    // clears the count. RUN follows 14 cycles after the final rise.
    p = cyc;
    applyStimulus(1'b0, 1'b0);
    pushState(p + 3, 1'b1, 2'd0);
    waitUntil(p + 6);
    q = cyc;
    applyStimulus(1'b0, 1'b1);
    pushState(q + 10, 1'b1, 2'd1);
    pushState(q + 18, 1'b0, 2'd2);
    waitUntil(q + 3);
    applyStimulus(1'b0, 1'b0);
    waitUntil(q + 4);
    applyStimulus(1'b0, 1'b1);
    waitUntil(q + 24);

    // Reset pulse in RUN. This is followed by a lock drop mid-HOLD, then a
    // lock drop on the HOLD terminal cycle, which lock loss must win.
    s = cyc;
    applyStimulus(1'b1, 1'b1);
    pushState(s + 1, 1'b1, 2'd0);
    pushState(s + 7, 1'b1, 2'd1);
    pushState(s + 12, 1'b1, 2'd0);
    pushState(s + 16, 1'b1, 2'd1);
    pushState(s + 24, 1'b1, 2'd0);
    pushState(s + 28, 1'b1, 2'd1);
    pushState(s + 36, 1'b0, 2'd2);
    waitUntil(s + 1);
    applyStimulus(1'b0, 1'b1);
    waitUntil(s + 9);
    applyStimulus(1'b0, 1'b0);
    waitUntil(s + 10);
    applyStimulus(1'b0, 1'b1);
    waitUntil(s + 21);
    applyStimulus(1'b0, 1'b0);
    waitUntil(s + 22);
    applyStimulus(1'b0, 1'b1);
    waitUntil(s + 36);

    // Long RUN window for the timebase. Lock is then lost on an edge that
    // would otherwise have produced a tick_us.
    e = cyc;
`ifdef SEQ_TICKS_EN
    for (int k = 1; k <= 1003; k++) begin
      tkEv.atCyc = e + 3 * k;
      tkEv.ms    = (k == 1000);
      tickQ.push_back(tkEv);
    end
    tickCheckEn = 1'b1;
`endif
    waitUntil(e + 3009);
    applyStimulus(1'b0, 1'b0);
    pushState(e + 3012, 1'b1, 2'd0);
    waitUntil(e + 3020);

    checkOutput("stateEventsLeft", stateQ.size(), 0);
`ifdef SEQ_TICKS_EN
    checkOutput("tickEventsLeft", tickQ.size(), 0);
`else
    checkOutput("tickIdle", tickHigh, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
